// File: rtl/move_scheduler.sv
// move_scheduler
//   Arbitrates paddle-move requests from the keyboard arrow keys and the
//   up/down push buttons. It issues at most one registered, single-cycle move
//   pulse per video frame, and a held request auto-repeats.
//
// Ports
//   clk         system clock (only clock)
//   reset       asynchronous active-low reset
//   frame_tick  one-cycle pulse per frame; decisions are taken only then
//   enable      low forces IDLE and blocks every move
//   kb_up/down  keyboard levels, asynchronous (synchronized here)
//   btn_up/down push-button levels, asynchronous (synchronized here)
//   move_up/dn  one-cycle move pulses, asserted the cycle after a tick
//   owner_valid a source currently owns the move channel
//   grant_src   last granted source (0 = keyboard, 1 = buttons)

// Per-input level synchronizer. The flops reset to 0.
module move_sync #(
  parameter int STAGES = 2
) (
  input  logic clk,
  input  logic reset,
  input  logic d,
  output logic q
);
  logic [STAGES-1:0] sync_pipe;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) sync_pipe <= '0;
    else        sync_pipe <= {sync_pipe[STAGES-2:0], d};
  end

  assign q = sync_pipe[STAGES-1];
endmodule

module move_scheduler #(
  parameter int SYNC_STAGES   = 2,
  parameter int REPEAT_DELAY  = 15,
  parameter int REPEAT_PERIOD = 4,
  parameter int CNT_W         = 6
) (
  input  logic clk,
  input  logic reset,
  input  logic frame_tick,
  input  logic enable,
  input  logic kb_up,
  input  logic kb_down,
  input  logic btn_up,
  input  logic btn_down,
  output logic move_up,
  output logic move_down,
  output logic owner_valid,
  output logic grant_src
);
  localparam int NUM_REQ = 4;
  localparam logic [CNT_W-1:0] DLY = CNT_W'(REPEAT_DELAY);
  localparam logic [CNT_W-1:0] PER = CNT_W'(REPEAT_PERIOD);

  typedef enum logic [1:0] {IDLE, HOLD, REPEAT} state_t;
  typedef enum logic [1:0] {DIR_NONE, DIR_UP, DIR_DN} dir_t;

  // Bit order: {btn_down, btn_up, kb_down, kb_up}
  logic [NUM_REQ-1:0] req_raw, req_s;
  assign req_raw = {btn_down, btn_up, kb_down, kb_up};

  for (genvar i = 0; i < NUM_REQ; i++) begin : g_sync
    move_sync #(.STAGES(SYNC_STAGES)) u_sync (
      .clk  (clk),
      .reset(reset),
      .d    (req_raw[i]),
      .q    (req_s[i])
    );
  end

  // Both directions pressed at once is treated as no request.
  function automatic dir_t decode(input logic up, input logic dn);
    if (up && !dn) return DIR_UP;
    if (dn && !up) return DIR_DN;
    return DIR_NONE;
  endfunction

  state_t           state;
  dir_t             owner_dir;
  logic             owner;
  logic             rr;
  logic [CNT_W-1:0] cnt;

  dir_t             kb_dir, btn_dir, own_dir, arb_dir;
  logic             kb_req, btn_req, arb_src;
  logic [CNT_W-1:0] cnt_inc, limit;

  assign kb_dir  = decode(req_s[0], req_s[1]);
  assign btn_dir = decode(req_s[2], req_s[3]);
  assign kb_req  = (kb_dir  != DIR_NONE);
  assign btn_req = (btn_dir != DIR_NONE);
  assign own_dir = owner ? btn_dir : kb_dir;

  // A tie goes to the source that rr points at. Otherwise the single
  // requester wins. When an owner releases, it is not requesting, so this
  // also picks the other source in the same tick.
  assign arb_src = (kb_req && btn_req) ? rr : btn_req;
  assign arb_dir = arb_src ? btn_dir : kb_dir;

  assign cnt_inc = cnt + CNT_W'(1);
  assign limit   = (state == HOLD) ? DLY : PER;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state       <= IDLE;
      owner       <= 1'b0;
      owner_dir   <= DIR_NONE;
      cnt         <= '0;
      rr          <= 1'b0;
      move_up     <= 1'b0;
      move_down   <= 1'b0;
      owner_valid <= 1'b0;
      grant_src   <= 1'b0;
    end else begin
      move_up   <= 1'b0;
      move_down <= 1'b0;
      if (!enable) begin
        // rr and grant_src are held so that arbitration history survives.
        state       <= IDLE;
        cnt         <= '0;
        owner_valid <= 1'b0;
      end else if (frame_tick) begin
        if (state == IDLE || own_dir == DIR_NONE) begin
          if (kb_req || btn_req) begin
            move_up     <= (arb_dir == DIR_UP);
            move_down   <= (arb_dir == DIR_DN);
            owner       <= arb_src;
            owner_dir   <= arb_dir;
            rr          <= ~arb_src;
            grant_src   <= arb_src;
            cnt         <= '0;
            state       <= HOLD;
            owner_valid <= 1'b1;
          end else begin
            state       <= IDLE;
            cnt         <= '0;
            owner_valid <= 1'b0;
          end
        end else if (own_dir != owner_dir) begin
          // A reversal counts as a fresh press. Ownership is kept.
          move_up   <= (own_dir == DIR_UP);
          move_down <= (own_dir == DIR_DN);
          owner_dir <= own_dir;
          cnt       <= '0;
          state     <= HOLD;
        end else if (cnt_inc == limit) begin
          move_up   <= (owner_dir == DIR_UP);
          move_down <= (owner_dir == DIR_DN);
          cnt       <= '0;
          state     <= REPEAT;
        end else begin
          cnt <= cnt_inc;
        end
      end
    end
  end
endmodule

// File: tb/tb_move_scheduler.sv
module tb_move_scheduler;
  localparam int DELAY  = 15;
  localparam int PERIOD = 4;
  localparam int GAP    = 5;   // cycles between input change and the tick

  logic clk = 1'b0;
  logic reset = 1'b0;
  logic frame_tick = 1'b0;
  logic enable = 1'b1;
  logic kb_up = 1'b0, kb_down = 1'b0, btn_up = 1'b0, btn_down = 1'b0;
  logic move_up, move_down, owner_valid, grant_src;

  move_scheduler dut (
    .clk        (clk),
    .reset      (reset),
    .frame_tick (frame_tick),
    .enable     (enable),
    .kb_up      (kb_up),
    .kb_down    (kb_down),
    .btn_up     (btn_up),
    .btn_down   (btn_down),
    .move_up    (move_up),
    .move_down  (move_down),
    .owner_valid(owner_valid),
    .grant_src  (grant_src)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic up;
    logic dn;
    logic ov;
    logic gs;
  } st_t;

  st_t sq[$];
  int  n_checks = 0;
  int  n_pass   = 0;

  // Reference model. It counts the frames a direction has been held and
  // moves at frame 0, at DELAY, and every PERIOD frames after DELAY.
  bit m_active;
  bit m_owner;
  bit m_rr;
  bit m_gs;
  int m_dir;   // 0 none, 1 up, 2 down
  int m_k;

  function automatic int dir_of(input logic u, input logic d);
    if (u && !d) return 1;
    if (d && !u) return 2;
    return 0;
  endfunction

  task automatic model_reset();
    m_active = 0; m_owner = 0; m_rr = 0; m_gs = 0; m_dir = 0; m_k = 0;
  endtask

  task automatic model_tick();
    int  dk, db, od, mv, src;
    st_t e;
    mv = 0;
    if (!reset) begin
      model_reset();
      sq.push_back('0);
      return;
    end
    if (!enable) begin
      m_active = 0;
      sq.push_back(st_t'{1'b0, 1'b0, 1'b0, m_gs});
      return;
    end
    dk = dir_of(kb_up, kb_down);
    db = dir_of(btn_up, btn_down);
    if (m_active) begin
      od = m_owner ? db : dk;
      if (od == 0) m_active = 0;
      else if (od != m_dir) begin
        m_dir = od; m_k = 0; mv = od;
      end else begin
        m_k++;
        if (m_k == DELAY || (m_k > DELAY && (m_k - DELAY) % PERIOD == 0)) mv = od;
      end
    end
    if (!m_active && (dk != 0 || db != 0)) begin
      if (dk != 0 && db != 0) src = int'(m_rr);
      else                    src = (db != 0) ? 1 : 0;
      m_owner  = (src == 1);
      m_dir    = (src == 1) ? db : dk;
      m_rr     = ~m_owner;
      m_gs     = m_owner;
      m_k      = 0;
      m_active = 1;
      mv       = m_dir;
    end
    e.up = (mv == 1);
    e.dn = (mv == 2);
    e.ov = m_active;
    e.gs = m_gs;
    sq.push_back(e);
  endtask

  // Monitor: compares outputs in the cycle after each tick against the
  // scoreboard. On every other cycle it requires that no pulse is present.
  bit last_tick = 0;
  always @(negedge clk) begin
    st_t e;
    if (last_tick) begin
      n_checks += 3;
      if (sq.size() == 0) begin
        $display("FAIL sb_underflow: post-tick cycle with no expected entry");
      end else begin
        e = sq.pop_front();
        if ({move_up, move_down} === {e.up, e.dn}) n_pass++;
        else $display("FAIL move t=%0t: got up=%b dn=%b, want up=%b dn=%b",
                      $time, move_up, move_down, e.up, e.dn);
        if (owner_valid === e.ov) n_pass++;
        else $display("FAIL owner_valid t=%0t: got %b, want %b", $time, owner_valid, e.ov);
        if (grant_src === e.gs) n_pass++;
        else $display("FAIL grant_src t=%0t: got %b, want %b", $time, grant_src, e.gs);
      end
    end else begin
      n_checks++;
      if (move_up === 1'b0 && move_down === 1'b0) n_pass++;
      else $display("FAIL stray_pulse t=%0t: got up=%b dn=%b, want 0 0",
                    $time, move_up, move_down);
    end
    last_tick = frame_tick;
  end

  // One frame: apply the levels, optionally pulse reset, let the
  // synchronizers settle, then issue a tick.
  task automatic run_frame(input logic ku, kd, bu, bd, en, input bit rst_pulse);
    kb_up = ku; kb_down = kd; btn_up = bu; btn_down = bd; enable = en;
    if (rst_pulse) begin
      // This lands in the post-tick cycle, so any pulse in flight is dropped.
      if (sq.size() > 0) sq[sq.size()-1] = '0;
      reset = 1'b0;
      model_reset();
      #1;
      n_checks++;
      if ({move_up, move_down, owner_valid, grant_src} === 4'b0000) n_pass++;
      else $display("FAIL async_reset t=%0t: got %b%b%b%b, want 0000",
                    $time, move_up, move_down, owner_valid, grant_src);
      repeat (2) @(posedge clk);
      #1 reset = 1'b1;
    end
    repeat (GAP) @(posedge clk);
    #1 frame_tick = 1'b1;
    model_tick();
    @(posedge clk);
    #1 frame_tick = 1'b0;
  endtask

  task automatic frames(input int n, input logic ku, kd, bu, bd, en);
    for (int i = 0; i < n; i++) run_frame(ku, kd, bu, bd, en, 1'b0);
  endtask

  initial begin
    logic [3:0] r;
    logic       en_r;
    model_reset();
    // Reset held while inputs toggle and ticks run.
    for (int i = 0; i < 4; i++) begin
      r = 4'($urandom);
      run_frame(r[0], r[1], r[2], r[3], 1'b1, 1'b0);
    end
    @(posedge clk); #1 reset = 1'b1;
    frames(2, 0, 0, 0, 0, 1);
    // Auto-repeat.
    frames(30, 1, 0, 0, 0, 1);
    frames(2, 0, 0, 0, 0, 1);
    // Tie and release, starting from a fresh rr.
    run_frame(0, 0, 0, 0, 1, 1'b1);
    frames(3, 1, 0, 0, 1, 1);
    frames(5, 0, 0, 0, 1, 1);
    frames(2, 0, 0, 0, 0, 1);
    // Conflict.
    frames(20, 1, 1, 0, 0, 1);
    // Direction change.
    frames(5, 1, 0, 0, 0, 1);
    frames(17, 0, 1, 0, 0, 1);
    frames(2, 0, 0, 0, 0, 1);
    // Enable drop during repeat.
    frames(17, 1, 0, 0, 0, 1);
    frames(8, 1, 0, 0, 0, 0);
    frames(17, 1, 0, 0, 0, 1);
    frames(2, 0, 0, 0, 0, 1);
    // Random traffic with occasional reset and enable drops.
    r = 4'b0; en_r = 1'b1;
    for (int i = 0; i < 250; i++) begin
      if ($urandom_range(3) == 0) r = 4'($urandom);
      if ($urandom_range(15) == 0) en_r = ~en_r;
      run_frame(r[0], r[1], r[2], r[3], en_r, $urandom_range(39) == 0);
    end
    repeat (3) @(posedge clk);
    #1;
    n_checks++;
    if (sq.size() == 0) n_pass++;
    else $display("FAIL sb_drain: %0d expected entries left, want 0", sq.size());
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
